// File: rtl/axis_operand_source.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : axis_operand_source
// Dual-channel AXI4-Stream operand source with frame-aligned a/b streams.
// Build option: AXIS_SRC_THROTTLE_EN gates new tvalids with per-channel LFSRs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module axis_operand_source #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FRAME_LEN  = 501,
    parameter int unsigned       NUM_FRAMES = 4,
    parameter logic [DATA_W-1:0] A_BASE     = '0,
    parameter logic [DATA_W-1:0] A_STEP     = DATA_W'(1),
    parameter logic [DATA_W-1:0] B_BASE     = DATA_W'(1),
    parameter logic [DATA_W-1:0] B_STEP     = '0
) (
    input  logic              clk_0,
    input  logic              rst_0,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_axis_a_tdata,
    output logic              m_axis_a_tlast,
    output logic              m_axis_a_tvalid,
    input  logic              m_axis_a_tready,
    output logic [DATA_W-1:0] m_axis_b_tdata,
    output logic              m_axis_b_tlast,
    output logic              m_axis_b_tvalid,
    input  logic              m_axis_b_tready
);

    localparam int unsigned BEAT_W  = $clog2(FRAME_LEN + 1);
    localparam int unsigned FRAME_W = $clog2(NUM_FRAMES + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FRAME_LEN - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic               FIRST_LAST = (FRAME_LEN == 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [FRAME_W-1:0] frame_q,  frame_d;
    logic [BEAT_W-1:0]  a_beat_q, a_beat_d;
    logic [BEAT_W-1:0]  b_beat_q, b_beat_d;
    logic               a_fin_q,  a_fin_d;
    logic               b_fin_q,  b_fin_d;
    logic               a_valid_q, a_valid_d;
    logic               b_valid_q, b_valid_d;
    logic               a_last_q, a_last_d;
    logic               b_last_q, b_last_d;
    logic [DATA_W-1:0]  a_data_q, a_data_d;
    logic [DATA_W-1:0]  b_data_q, b_data_d;
    logic               done_q,   done_d;

    logic               a_gate;
    logic               b_gate;
    logic               a_hs;
    logic               b_hs;
    logic               a_fin_now;
    logic               b_fin_now;
    logic               advance;
    logic               final_frame;
    logic [BEAT_W-1:0]  a_beat_inc;
    logic [BEAT_W-1:0]  b_beat_inc;

`ifdef AXIS_SRC_THROTTLE_EN
    logic [15:0] lfsr_a_q;
    logic [15:0] lfsr_b_q;

    // x^16 + x^14 + x^13 + x^11 + 1, free-running only while a run is active
    always_ff @(posedge clk_0) begin
        if (rst_0) begin
            lfsr_a_q <= 16'hACE1;
            lfsr_b_q <= 16'h1D0F;
        end else if (state_q == S_RUN) begin
            lfsr_a_q <= {lfsr_a_q[14:0], lfsr_a_q[15] ^ lfsr_a_q[13] ^ lfsr_a_q[12] ^ lfsr_a_q[10]};
            lfsr_b_q <= {lfsr_b_q[14:0], lfsr_b_q[15] ^ lfsr_b_q[13] ^ lfsr_b_q[12] ^ lfsr_b_q[10]};
        end
    end

    assign a_gate = lfsr_a_q[0];
    assign b_gate = lfsr_b_q[0];
`else
    assign a_gate = 1'b1;
    assign b_gate = 1'b1;
`endif

    assign a_hs        = a_valid_q & m_axis_a_tready;
    assign b_hs        = b_valid_q & m_axis_b_tready;
    assign a_fin_now   = a_fin_q | (a_hs & a_last_q);
    assign b_fin_now   = b_fin_q | (b_hs & b_last_q);
    assign advance     = (state_q == S_RUN) & a_fin_now & b_fin_now;
    assign final_frame = advance & (frame_q == LAST_FRAME);
    assign a_beat_inc  = a_beat_q + 1'b1;
    assign b_beat_inc  = b_beat_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        a_beat_d  = a_beat_q;
        b_beat_d  = b_beat_q;
        a_fin_d   = a_fin_q;
        b_fin_d   = b_fin_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        a_last_d  = a_last_q;
        b_last_d  = b_last_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    frame_d   = '0;
                    a_beat_d  = '0;
                    b_beat_d  = '0;
                    a_fin_d   = 1'b0;
                    b_fin_d   = 1'b0;
                    a_valid_d = a_gate;
                    b_valid_d = b_gate;
                    a_last_d  = FIRST_LAST;
                    b_last_d  = FIRST_LAST;
                    a_data_d  = A_BASE;
                    b_data_d  = B_BASE;
                end
            end

            S_RUN: begin
                if (a_hs) begin
                    if (a_last_q) begin
                        a_fin_d   = 1'b1;
                        a_valid_d = 1'b0;
                    end else begin
                        a_beat_d  = a_beat_inc;
                        a_data_d  = a_data_q + A_STEP;
                        a_last_d  = (a_beat_inc == LAST_BEAT);
                        a_valid_d = a_gate;
                    end
                end else if (!a_valid_q && !a_fin_q) begin
                    a_valid_d = a_gate;
                end

                // B keeps accumulating across frames, including on its last beat
                if (b_hs) begin
                    b_data_d = b_data_q + B_STEP;
                    if (b_last_q) begin
                        b_fin_d   = 1'b1;
                        b_valid_d = 1'b0;
                    end else begin
                        b_beat_d  = b_beat_inc;
                        b_last_d  = (b_beat_inc == LAST_BEAT);
                        b_valid_d = b_gate;
                    end
                end else if (!b_valid_q && !b_fin_q) begin
                    b_valid_d = b_gate;
                end

                if (advance) begin
                    a_fin_d  = 1'b0;
                    b_fin_d  = 1'b0;
                    a_beat_d = '0;
                    b_beat_d = '0;
                    a_last_d = FIRST_LAST;
                    b_last_d = FIRST_LAST;
                    a_data_d = A_BASE;
                    if (final_frame) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        a_valid_d = 1'b0;
                        b_valid_d = 1'b0;
                    end else begin
                        frame_d   = frame_q + 1'b1;
                        a_valid_d = a_gate;
                        b_valid_d = b_gate;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (rst_0) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            a_beat_q  <= '0;
            b_beat_q  <= '0;
            a_fin_q   <= 1'b0;
            b_fin_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            b_last_q  <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            a_beat_q  <= a_beat_d;
            b_beat_q  <= b_beat_d;
            a_fin_q   <= a_fin_d;
            b_fin_q   <= b_fin_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_last_q  <= a_last_d;
            b_last_q  <= b_last_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            done_q    <= done_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = done_q;
    assign m_axis_a_tdata  = a_data_q;
    assign m_axis_a_tlast  = a_last_q;
    assign m_axis_a_tvalid = a_valid_q;
    assign m_axis_b_tdata  = b_data_q;
    assign m_axis_b_tlast  = b_last_q;
    assign m_axis_b_tvalid = b_valid_q;

endmodule
`default_nettype wire

// File: doc/axis_operand_source.md
# axis_operand_source

Dual-channel AXI4-Stream operand transmitter that drives the `a` and `b` slave ports of the AXIS multiplier. It emits framed operand sequences on two independent master streams with per-channel backpressure handling. Frames on the two channels stay aligned, and a start/busy/done control interface lets the block run a fixed number of frames. It sits upstream of the multiplier and replaces ad-hoc bench stimulus in system-level builds.

## Interface
- `DATA_W`, 32: tdata width of both channels.
- `FRAME_LEN`, 501: beats per frame, ≥1; tlast on beat FRAME_LEN-1.
- `NUM_FRAMES`, 4: frames per run, ≥1.
- `A_BASE`, 0: channel A value on beat 0 of every frame.
- `A_STEP`, 1: channel A per-beat increment.
- `B_BASE`, 1: channel B value on first beat after start.
- `B_STEP`, 0: channel B per-beat increment; continues across frames.
- `clk_0`  in  1  clock; all logic on the rising edge.
- `rst_0`  in  1  reset; synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the final frame completes.
- `m_axis_a_tdata`  out  DATA_W  channel A operand.
- `m_axis_a_tlast`  out  1  channel A end of frame.
- `m_axis_a_tvalid`  out  1  channel A valid.
- `m_axis_a_tready`  in  1  channel A ready.
- `m_axis_b_tdata`, `m_axis_b_tlast`, `m_axis_b_tvalid` (out), `m_axis_b_tready` (in): same widths and meaning for channel B.

## Operation
- FSM: IDLE → RUN on `start`=1. RUN → IDLE when the last beat of frame NUM_FRAMES-1 has handshaken on both channels. Any `start` pulse in RUN is ignored.
- Each channel has a beat counter (0..FRAME_LEN-1) and a `fin` flag.
- A handshake is tvalid&tready. On a non-last handshake the beat counter increments.
- Channel A data = A_BASE + beat*A_STEP, modulo 2^DATA_W, and restarts every frame.
- Channel B data starts at B_BASE on entry to RUN and adds B_STEP on every B handshake, modulo 2^DATA_W, with no frame restart.
- A last-beat handshake sets the channel's `fin` flag and drops its tvalid. That channel then waits.
- Frame advance happens when both `fin` are set, or are set in the same cycle. Then: clear both `fin` and beat counters, increment the frame counter, and drive beat 0 of the next frame on both channels.
- After the final frame: pulse `done`, enter IDLE, and drop both tvalid.
- AXIS rules: once tvalid is high, tdata/tlast/tvalid hold stable until the handshake. tvalid never depends combinationally on tready.
- The frame counter width is clog2(NUM_FRAMES+1). The beat counter width is clog2(FRAME_LEN+1).

## Timing
- Reset values: busy=0, done=0, all tvalid=0, all tlast=0, all tdata=0, FSM=IDLE, counters=0.
- Reset asserted mid-run takes effect on the next edge. Any pending beat is dropped with no completion, and no `done` pulse is produced.
- `start` high at edge N → busy=1 and both tvalid=1 with beat 0 from edge N+1.
- Throughput is 1 beat/cycle/channel while tready stays high. No bubble between frames when both channels finish together.
- If one channel finishes first, its tvalid stays 0 until the cycle after the other channel's last handshake. Both then present beat 0 on the same cycle.
- FRAME_LEN=1: every beat carries tlast=1.
- `done` is high for exactly the cycle after the final handshake, coincident with busy=0. A `start` seen in that same IDLE cycle launches a new run.

## Configuration
- `AXIS_SRC_THROTTLE_EN` defined: each channel gets a 16-bit LFSR, with seeds 16'hACE1 (A) and 16'h1D0F (B), stepped every cycle in RUN.
  - A new beat's tvalid is raised only when LFSR bit 0 = 1.
  - An already-raised tvalid is never withdrawn.
  - Data sequences are unchanged; only cycle placement differs.
- Not defined: no LFSR logic. tvalid is raised as soon as a beat is available.

## Test plan
- FRAME_LEN=4, NUM_FRAMES=2, both treadys held high, start pulse:
  - A = 0,1,2,3,0,1,2,3; B = 1×8.
  - tlast on beats 3 and 7.
  - 8 consecutive valid cycles, then `done` pulse.
- Channel A tready low for 3 cycles mid-frame → A tdata/tvalid/tlast stay frozen during the stall. B finishes its frame and waits with tvalid=0 until A's last beat. Both then restart together.
- B_STEP=2, B_BASE=32'hFFFF_FFFE, FRAME_LEN=3, NUM_FRAMES=1 → B = FFFF_FFFE, 0000_0000, 0000_0002 (wrap).
- `rst_0` pulsed during beat 2 of frame 0 → next cycle all outputs are at reset values and no `done` appears. A fresh `start` replays from A_BASE/B_BASE.
- `start` held high across a full run → the run does not restart mid-run. A second run begins on the cycle `done` is asserted.
- With `AXIS_SRC_THROTTLE_EN`, tready high → the same data/tlast sequence as the unthrottled run. The bench checks that no tvalid falls without a handshake.
